// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and helpers for the CPU instruction/data bus arbiter.
// Round-robin arbitration is enabled by CPU_BUS_ARBITER_ROUND_ROBIN_EN.
package cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_IBUS,
        GRANT_DBUS
    } grant_t;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'h0000_0000;

    // Data wins a tie unless the caller asks to favour fetch.
    function automatic grant_t pick_grant(
        input logic ireq,
        input logic dreq,
        input logic prefer_i
    );
        grant_t g;
        g = GRANT_NONE;
        if (ireq && dreq) begin
            g = prefer_i ? GRANT_IBUS : GRANT_DBUS;
        end else if (dreq) begin
            g = GRANT_DBUS;
        end else if (ireq) begin
            g = GRANT_IBUS;
        end
        return g;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_timeout.sv
// Grant watchdog: clearable up-counter that flags the last allowed cycle.
// TIMEOUT of 0 keeps expired_o low permanently.
module cpu_bus_arbiter_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit ENABLED = (TIMEOUT > 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = ENABLED && (count_q == LAST);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between CPU fetch and data ports, with timeout.
// Define CPU_BUS_ARBITER_ROUND_ROBIN_EN for round-robin tie breaking.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT       = 1024,
    parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic        o_busy,
    output logic        o_fault
);

    state_t state_q;
    grant_t owner_q;
    grant_t pick_d;
    logic   bus_req_q;
    logic   fault_q;
    logic   prefer_i;

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    grant_t rr_last_q;
    assign prefer_i = (rr_last_q == GRANT_DBUS);
`else
    assign prefer_i = 1'b0;
`endif

    logic gnt_i;
    logic gnt_d;
    logic granted;
    logic expired;
    logic done;
    logic tmo_hit;
    logic owner_req;
    logic [31:0] rdata;

    assign gnt_i   = (state_q == GRANT_I);
    assign gnt_d   = (state_q == GRANT_D);
    assign granted = gnt_i | gnt_d;
    assign done    = granted & (i_bus_ready | expired);
    assign tmo_hit = granted & expired & ~i_bus_ready;

    always_comb begin
        pick_d = pick_grant(i_ibus_request, i_dbus_request, prefer_i);
    end

    always_comb begin
        owner_req = 1'b0;
        unique case (1'b1)
            owner_q == GRANT_IBUS: owner_req = i_ibus_request;
            owner_q == GRANT_DBUS: owner_req = i_dbus_request;
            default:               owner_req = 1'b0;
        endcase
    end

    cpu_bus_arbiter_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (i_clock),
        .rst_ni    (i_reset),
        .clear_i   (~granted),
        .enable_i  (granted & ~i_bus_ready),
        .expired_o (expired)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            owner_q   <= GRANT_NONE;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b0;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
            rr_last_q <= GRANT_DBUS;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d != GRANT_NONE) begin
                        state_q   <= (pick_d == GRANT_DBUS) ? GRANT_D : GRANT_I;
                        owner_q   <= pick_d;
                        bus_req_q <= 1'b1;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
                        rr_last_q <= pick_d;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done) begin
                        state_q   <= RELEASE;
                        bus_req_q <= 1'b0;
                        if (tmo_hit) begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // Wait for the requester to drop so a held request is not replayed.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        owner_q <= GRANT_NONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    owner_q   <= GRANT_NONE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_bus_address = '0;
        o_bus_rw      = 1'b0;
        o_bus_wdata   = '0;
        unique case (1'b1)
            gnt_i: begin
                o_bus_address = i_ibus_address;
            end
            gnt_d: begin
                o_bus_address = i_dbus_address;
                o_bus_rw      = i_dbus_rw;
                o_bus_wdata   = i_dbus_wdata;
            end
            default: begin
                o_bus_address = '0;
            end
        endcase
    end

    assign rdata        = tmo_hit ? TIMEOUT_RDATA : i_bus_rdata;
    assign o_ibus_ready = gnt_i & done;
    assign o_dbus_ready = gnt_d & done;
    assign o_ibus_rdata = o_ibus_ready ? rdata : '0;
    assign o_dbus_rdata = o_dbus_ready ? rdata : '0;

    assign o_bus_request = bus_req_q;
    assign o_busy        = (state_q != IDLE);
    assign o_fault       = fault_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter with a latency-keyed memory slave.
module tb_cpu_bus_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] WR_ACK = 32'h0BAD_0ACC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq;
    logic        irdy;
    logic [31:0] iaddr;
    logic [31:0] irdata;
    logic        drw;
    logic        dreq;
    logic        drdy;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        brw;
    logic        breq;
    logic        brdy;
    logic [31:0] baddr;
    logic [31:0] brdata;
    logic [31:0] bwdata;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(
        .TIMEOUT       (TO),
        .TIMEOUT_RDATA (32'h0)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_ibus_request (ireq),
        .o_ibus_ready   (irdy),
        .i_ibus_address (iaddr),
        .o_ibus_rdata   (irdata),
        .i_dbus_rw      (drw),
        .i_dbus_request (dreq),
        .o_dbus_ready   (drdy),
        .i_dbus_address (daddr),
        .i_dbus_wdata   (dwdata),
        .o_dbus_rdata   (drdata),
        .o_bus_rw       (brw),
        .o_bus_request  (breq),
        .i_bus_ready    (brdy),
        .o_bus_address  (baddr),
        .i_bus_rdata    (brdata),
        .o_bus_wdata    (bwdata),
        .o_busy         (busy),
        .o_fault        (fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    bit   order[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    bit   model_fault = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   slave_cnt = 0;
    exp_t mon_e;

    function automatic int lat(input logic [31:0] a);
        if (a == 32'h100) return 3;
        return int'(a[5:2]) % 10 + 1;
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h100) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Bus slave: ready after lat(addr) request cycles; spurious ready otherwise.
    always @(posedge clk) begin
        #1;
        if (breq) begin
            slave_cnt++;
            if (slave_cnt == lat(baddr)) begin
                brdy = 1'b1;
                if (brw) begin
                    slave_mem[baddr] = bwdata;
                    brdata = WR_ACK;
                end else begin
                    brdata = slave_mem.exists(baddr) ? slave_mem[baddr] : pat(baddr);
                end
            end else begin
                brdy = 1'b0;
                brdata = $urandom;
            end
        end else begin
            slave_cnt = 0;
            brdy = 1'($urandom_range(0, 1));
            brdata = $urandom;
        end
    end

    // Monitor: pops the expected response whenever a port sees ready.
    always @(negedge clk) begin
        if (irdy && drdy) begin
            chk("both_ready", {irdy, drdy}, 32'h1);
        end
        if (irdy) begin
            order.push_back(1'b0);
            if (exp_i.size() == 0) begin
                chk("ibus_unexpected_ready", irdy, 32'h0);
            end else begin
                mon_e = exp_i.pop_front();
                chk("ibus_rdata", irdata, mon_e.rdata);
                chk("ibus_addr", baddr, mon_e.addr);
                chk("ibus_rw", brw, mon_e.rw);
                chk("ibus_cycles", 32'(slave_cnt), 32'(mon_e.cycles));
            end
        end else begin
            chk("ibus_rdata_idle", irdata, 32'h0);
        end
        if (drdy) begin
            order.push_back(1'b1);
            if (exp_d.size() == 0) begin
                chk("dbus_unexpected_ready", drdy, 32'h0);
            end else begin
                mon_e = exp_d.pop_front();
                chk("dbus_rdata", drdata, mon_e.rdata);
                chk("dbus_addr", baddr, mon_e.addr);
                chk("dbus_rw", brw, mon_e.rw);
                if (mon_e.rw) chk("dbus_wdata", bwdata, mon_e.wdata);
                chk("dbus_cycles", 32'(slave_cnt), 32'(mon_e.cycles));
            end
        end else begin
            chk("dbus_rdata_idle", drdata, 32'h0);
        end
    end

    task automatic hold_release(input int hold, input string tag);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_busreq"}, breq, 32'h0);
            chk({tag, "_hold_busy"}, busy, 32'h1);
        end
    endtask

    task automatic ibus_txn(input logic [31:0] a, input int hold);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        iaddr = a;
        ireq = 1'b1;
        e.addr = a;
        e.rw = 1'b0;
        e.wdata = '0;
        e.rdata = (lat(a) <= TO) ? pat(a) : 32'h0;
        e.cycles = (lat(a) <= TO) ? lat(a) : TO;
        if (lat(a) > TO) model_fault = 1'b1;
        exp_i.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irdy && n < 300);
        chk("ibus_wait", irdy, 32'h1);
        hold_release(hold, "ibus");
        @(posedge clk);
        #1;
        ireq = 1'b0;
    endtask

    task automatic dbus_txn(input logic rw, input logic [31:0] a,
                            input logic [31:0] wd, input int hold);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        drw = rw;
        daddr = a;
        dwdata = wd;
        dreq = 1'b1;
        e.addr = a;
        e.rw = rw;
        e.wdata = wd;
        e.cycles = (lat(a) <= TO) ? lat(a) : TO;
        if (lat(a) > TO) begin
            e.rdata = 32'h0;
            model_fault = 1'b1;
        end else if (rw) begin
            e.rdata = WR_ACK;
            model_mem[a] = wd;
        end else begin
            e.rdata = model_mem.exists(a) ? model_mem[a] : pat(a);
        end
        exp_d.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drdy && n < 300);
        chk("dbus_wait", drdy, 32'h1);
        hold_release(hold, "dbus");
        @(posedge clk);
        #1;
        dreq = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        ireq = 1'b0;
        iaddr = '0;
        drw = 1'b0;
        dreq = 1'b0;
        daddr = '0;
        dwdata = '0;
        brdy = 1'b0;
        brdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busreq", breq, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_fault", fault, 32'h0);
        chk("rst_ready", {irdy, drdy}, 32'h0);
        chk("rst_addr", baddr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        ibus_txn(32'h0000_0100, 0);
        dbus_txn(1'b0, 32'h1000_0004, '0, 0);

        order.delete();
        fork
            dbus_txn(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 0);
            ibus_txn(32'h0000_0200, 0);
        join
        chk("tie_count", 32'(order.size()), 32'h2);
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
        chk("tie_first", {31'h0, order[0]}, 32'h0);
`else
        chk("tie_first", {31'h0, order[0]}, 32'h1);
`endif
        dbus_txn(1'b0, 32'h1000_0000, '0, 0);

        ibus_txn(32'h0000_0304, 3);
        dbus_txn(1'b0, 32'h1000_0008, '0, 3);

        ibus_txn(32'h0000_001C, 0);
        chk("edge_no_fault", fault, 32'h0);

        ibus_txn(32'h0000_0020, 0);
        chk("tmo_fault", fault, 32'h1);
        dbus_txn(1'b1, 32'h1000_0010, 32'h5555_AAAA, 1);
        chk("tmo_fault_sticky", fault, 32'h1);

        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                ibus_txn(32'($urandom_range(0, 1023)) << 2, $urandom_range(0, 2));
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                dbus_txn(1'($urandom_range(0, 1)),
                         32'h1000_0000 | (32'($urandom_range(0, 15)) << 2),
                         $urandom, $urandom_range(0, 2));
            end
        join
        chk("rand_fault", fault, {31'h0, model_fault});
        chk("rand_drained", 32'(exp_i.size() + exp_d.size()), 32'h0);

        @(posedge clk);
        #1;
        drw = 1'b0;
        daddr = 32'h1000_0024;
        dreq = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!breq && n < 50);
        chk("abort_granted", breq, 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busreq", breq, 32'h0);
        chk("abort_busy", busy, 32'h0);
        chk("abort_fault", fault, 32'h0);
        chk("abort_ready", drdy, 32'h0);
        model_fault = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_ready", drdy, 32'h0);
        end
        @(posedge clk);
        #1;
        dreq = 1'b0;
        rst_n = 1'b1;
        ibus_txn(32'h0000_0040, 0);
        chk("post_reset_fault", fault, {31'h0, model_fault});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
